gps_chan_ctrl: RTL and testbench

- Parametrised successor to the flat per-satellite register bank: the control-plane block between the AXI register file and gps_emulator.
- Holds double-buffered (shadow/active) per-satellite configuration and commits it atomically, either immediately or on the next C/A epoch.
- Applies a per-channel Doppler-rate ramp to the active frequency on every epoch.
- Provides registered readback of both shadow and active state.

---
 rtl/gps_chan_ctrl_pkg.sv | 37 +++
 rtl/gps_chan_slot.sv | 63 ++++++
 rtl/gps_chan_ctrl.sv | 128 ++++++++++++
 tb/tb_gps_chan_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gps_chan_ctrl_pkg.sv
// Shared register map, field offsets and channel configuration type for the
// GPS channel control plane.
package gps_ctrl_pkg;

    localparam int ADDR_ID      = 0;
    localparam int ADDR_VERSION = 1;
    localparam int ADDR_CTRL    = 2;
    localparam int ADDR_STATUS  = 3;
    localparam int ADDR_NOISE   = 7;

    localparam int OFS_FREQ = 0;
    localparam int OFS_GAIN = 1;
    localparam int OFS_CA   = 2;
    localparam int OFS_RATE = 3;

    localparam logic [31:0] ID_VALUE      = 32'hdeadbeef;
    localparam logic [31:0] VERSION_VALUE = 32'h00020000;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] gain;
        logic [5:0]  ca_sel;
        logic [31:0] rate;
    } chan_cfg_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gps_chan_slot.sv
// One satellite channel: byte-merged shadow registers, atomic commit to the
// active set, and per-epoch Doppler-rate ramp of the active frequency.
module gps_chan_slot
    import gps_ctrl_pkg::*;
#(
    parameter int Naddr = 5,
    parameter int Base  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [Naddr-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             commit,
    input  logic             ramp,
    output chan_cfg_t        shadow,
    output chan_cfg_t        active
);

    localparam logic [Naddr-1:0] A_FREQ = Naddr'(Base + OFS_FREQ);
    localparam logic [Naddr-1:0] A_GAIN = Naddr'(Base + OFS_GAIN);
    localparam logic [Naddr-1:0] A_CA   = Naddr'(Base + OFS_CA);
    localparam logic [Naddr-1:0] A_RATE = Naddr'(Base + OFS_RATE);

    logic [31:0] cur_word;
    logic [31:0] merged;

    always_comb begin
        cur_word = '0;
        case (wr_addr)
            A_FREQ:  cur_word = shadow.freq;
            A_GAIN:  cur_word = {16'h0, shadow.gain};
            A_CA:    cur_word = {26'h0, shadow.ca_sel};
            A_RATE:  cur_word = shadow.rate;
            default: cur_word = '0;
        endcase
        merged = merge_bytes(cur_word, wr_data, wr_strb);
    end

    // Commit samples the shadow before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (commit)
                active <= shadow;
            else if (ramp)
                active.freq <= active.freq + active.rate;
            if (wr_en) begin
                case (wr_addr)
                    A_FREQ:  shadow.freq   <= merged;
                    A_GAIN:  shadow.gain   <= merged[15:0];
                    A_CA:    shadow.ca_sel <= merged[5:0];
                    A_RATE:  shadow.rate   <= merged;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/gps_chan_ctrl.sv
// Control-plane register block for gps_emulator: CTRL/STATUS/NOISE registers,
// commit sequencing, per-channel slots and a registered readback path.
module gps_chan_ctrl
    import gps_ctrl_pkg::*;
#(
    parameter int Nsat   = 4,
    parameter int Nregs  = 32,
    parameter int Naddr  = $clog2(Nregs),
    parameter int Nstart = 8,
    parameter int Nstep  = 4,
    parameter int Nact   = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [Naddr-1:0]      wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb,
    input  logic                  rd_en,
    input  logic [Naddr-1:0]      rd_addr,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  epoch,
    output logic                  gps_enable,
    output logic [Nsat-1:0][31:0] sat_freq,
    output logic [Nsat-1:0][15:0] sat_gain,
    output logic [Nsat-1:0][5:0]  sat_ca_sel,
    output logic [15:0]           gps_noise_gain
);

    if (!((Nstart + Nstep*Nsat <= Nact) && (Nact + Nsat <= Nregs))) begin : g_bad_map
        $error("gps_chan_ctrl: channel blocks overlap or exceed the address space");
    end

    logic        enable, commit_mode, pending;
    logic [7:0]  commit_count;
    logic [15:0] noise;
    logic        ctrl_wr, mode_next, req, commit, ramp;
    logic [31:0] rd_word;
    chan_cfg_t   shadow [Nsat];
    chan_cfg_t   active [Nsat];

    // The mode written alongside commit_req decides how that request is handled.
    assign ctrl_wr   = wr_en && (wr_addr == Naddr'(ADDR_CTRL));
    assign mode_next = (ctrl_wr && wr_strb[0]) ? wr_data[1] : commit_mode;
    assign req       = ctrl_wr && wr_strb[0] && wr_data[2];
    assign commit    = (req && !mode_next) || (epoch && pending);
    assign ramp      = epoch && enable && !commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            enable       <= 1'b0;
            commit_mode  <= 1'b0;
            pending      <= 1'b0;
            commit_count <= '0;
            noise        <= '0;
        end else begin
            if (ctrl_wr && wr_strb[0]) begin
                enable      <= wr_data[0];
                commit_mode <= wr_data[1];
            end
            if (commit) begin
                pending      <= 1'b0;
                commit_count <= commit_count + 8'd1;
            end else if (req && mode_next) begin
                pending <= 1'b1;
            end
            if (wr_en && (wr_addr == Naddr'(ADDR_NOISE))) begin
                if (wr_strb[0]) noise[7:0]  <= wr_data[7:0];
                if (wr_strb[1]) noise[15:8] <= wr_data[15:8];
            end
        end
    end

    for (genvar ch = 0; ch < Nsat; ch++) begin : g_slot
        gps_chan_slot #(
            .Naddr(Naddr),
            .Base (Nstart + Nstep*ch)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .wr_strb(wr_strb),
            .commit (commit),
            .ramp   (ramp),
            .shadow (shadow[ch]),
            .active (active[ch])
        );
        assign sat_freq[ch]   = active[ch].freq;
        assign sat_gain[ch]   = active[ch].gain;
        assign sat_ca_sel[ch] = active[ch].ca_sel;
    end

    assign gps_enable     = enable;
    assign gps_noise_gain = noise;

    always_comb begin
        rd_word = '0;
        case (rd_addr)
            Naddr'(ADDR_ID):      rd_word = ID_VALUE;
            Naddr'(ADDR_VERSION): rd_word = VERSION_VALUE;
            Naddr'(ADDR_CTRL):    rd_word = {30'h0, commit_mode, enable};
            Naddr'(ADDR_STATUS):  rd_word = {16'h0, commit_count, 7'h0, pending};
            Naddr'(ADDR_NOISE):   rd_word = {16'h0, noise};
            default:              rd_word = '0;
        endcase
        for (int unsigned ch = 0; ch < Nsat; ch++) begin
            if (rd_addr == Naddr'(Nstart + Nstep*ch + OFS_FREQ)) rd_word = shadow[ch].freq;
            if (rd_addr == Naddr'(Nstart + Nstep*ch + OFS_GAIN)) rd_word = {16'h0, shadow[ch].gain};
            if (rd_addr == Naddr'(Nstart + Nstep*ch + OFS_CA))   rd_word = {26'h0, shadow[ch].ca_sel};
            if (rd_addr == Naddr'(Nstart + Nstep*ch + OFS_RATE)) rd_word = shadow[ch].rate;
            if (rd_addr == Naddr'(Nact + ch))                    rd_word = active[ch].freq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_gps_chan_ctrl.sv
// Directed self-checking bench for gps_chan_ctrl with hand-computed expectations.
module tb_gps_chan_ctrl;

    localparam int Nsat  = 4;
    localparam int Naddr = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr_en;
    logic [Naddr-1:0]      wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  rd_en;
    logic [Naddr-1:0]      rd_addr;
    logic [31:0]           rd_data;
    logic                  rd_valid;
    logic                  epoch;
    logic                  gps_enable;
    logic [Nsat-1:0][31:0] sat_freq;
    logic [Nsat-1:0][15:0] sat_gain;
    logic [Nsat-1:0][5:0]  sat_ca_sel;
    logic [15:0]           gps_noise_gain;

    int errors = 0;
    int checks = 0;

    gps_chan_ctrl #(
        .Nsat  (Nsat),
        .Nregs (32),
        .Nstart(8),
        .Nstep (4),
        .Nact  (24)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .epoch         (epoch),
        .gps_enable    (gps_enable),
        .sat_freq      (sat_freq),
        .sat_gain      (sat_gain),
        .sat_ca_sel    (sat_ca_sel),
        .gps_noise_gain(gps_noise_gain)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = Naddr'(addr); wr_data = data; wr_strb = strb;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int addr, input logic [31:0] exp);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = Naddr'(addr);
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, rd_data, exp);
        @(negedge clk);
        check({tag, "_vdrop"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic pulse_epoch();
        @(negedge clk);
        epoch = 1'b1;
        @(negedge clk);
        epoch = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en = 1'b0; rd_addr = '0; epoch = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        check("rst_en", 32'(gps_enable), 32'd0);
        check("rst_freq0", sat_freq[0], 32'd0);
        rd_check("id", 0, 32'hdeadbeef);
        rd_check("version", 1, 32'h00020000);
        rd_check("status0", 3, 32'd0);
        rd_check("shadow0", 8, 32'd0);

        // Immediate commit of channel 1
        wr(12, 32'h00100000, 4'hf);
        wr(13, 32'h00004000, 4'hf);
        wr(14, 32'd5, 4'hf);
        wr(2, 32'h5, 4'hf);
        check("imm_freq1", sat_freq[1], 32'h00100000);
        check("imm_gain1", 32'(sat_gain[1]), 32'h4000);
        check("imm_ca1", 32'(sat_ca_sel[1]), 32'd5);
        check("imm_en", 32'(gps_enable), 32'd1);
        rd_check("imm_status", 3, 32'h00000100);

        // Epoch-mode commit
        wr(12, 32'h00200000, 4'hf);
        wr(2, 32'h6, 4'hf);
        check("ep_hold", sat_freq[1], 32'h00100000);
        rd_check("ep_pend", 3, 32'h00000101);
        check("ep_hold2", sat_freq[1], 32'h00100000);
        pulse_epoch();
        check("ep_freq1", sat_freq[1], 32'h00200000);
        rd_check("ep_status", 3, 32'h00000200);

        // Ramp with wrap past 2^32
        wr(8, 32'hFFFFFFF0, 4'hf);
        wr(11, 32'h00000020, 4'hf);
        wr(2, 32'h5, 4'hf);
        check("ramp_start", sat_freq[0], 32'hFFFFFFF0);
        pulse_epoch();
        check("ramp_wrap", sat_freq[0], 32'h00000010);
        wr(8, 32'h00000010, 4'hf);
        wr(11, 32'hFFFFFFFF, 4'hf);
        wr(2, 32'h5, 4'hf);
        repeat (3) pulse_epoch();
        check("ramp_neg", sat_freq[0], 32'h0000000D);
        check("ramp_ch1", sat_freq[1], 32'h00200000);
        rd_check("act_rb0", 24, 32'h0000000D);

        // Commit coincident with epoch: no rate added that cycle
        wr(8, 32'h00001000, 4'hf);
        wr(11, 32'h00000100, 4'hf);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = Naddr'(2); wr_data = 32'h5; wr_strb = 4'hf; epoch = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; epoch = 1'b0;
        check("coinc_freq", sat_freq[0], 32'h00001000);
        pulse_epoch();
        check("coinc_ramp", sat_freq[0], 32'h00001100);

        // Byte strobes, RO and unmapped addresses
        wr(16, 32'h11223344, 4'hf);
        wr(16, 32'hAABBCCDD, 4'h2);
        rd_check("strb", 16, 32'h1122CC44);
        wr(0, 32'h0, 4'hf);
        rd_check("id_ro", 0, 32'hdeadbeef);
        rd_check("unmapped", 5, 32'd0);
        wr(7, 32'h12345678, 4'hf);
        check("noise_out", 32'(gps_noise_gain), 32'h5678);

        // Simultaneous read and write returns the old value
        @(negedge clk);
        wr_en = 1'b1; wr_addr = Naddr'(7); wr_data = 32'h0000BEEF; wr_strb = 4'hf;
        rd_en = 1'b1; rd_addr = Naddr'(7);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_old", rd_data, 32'h00005678);
        check("rw_new", 32'(gps_noise_gain), 32'hBEEF);

        // Reset cancels a pending commit
        wr(2, 32'h6, 4'hf);
        rd_check("pre_rst", 3, 32'h00000501);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst2_freq0", sat_freq[0], 32'd0);
        check("rst2_noise", 32'(gps_noise_gain), 32'd0);
        rd_check("rst2_status", 3, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
